// File: rtl/if_stage_if.sv
// Instruction-SRAM port bundle between the fetch stage (master) and the SRAM (slave).
// Read data returns one cycle after a request with inst_sram_en high.
interface if_stage_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, SRAM fetch request and a one-entry
// instruction buffer that holds the fetched word while decode is stalled.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic              clk,
    input  logic              resetn,
    if_stage_if.master        inst_sram,
    input  logic              ds_allowin,
    output logic              fs2ds_valid,
    output logic [63:0]       fs2ds_bus,
    input  logic [32:0]       br_zip,
    input  logic              wb_ex,
    input  logic [31:0]       ex_entry,
    input  logic              ertn_flush,
    input  logic [31:0]       era
);

    logic        preif_valid_reg;
    logic        fs_valid_reg;
    logic        buf_valid_reg;
    logic [31:0] fs_pc_reg;
    logic [31:0] inst_buf_reg;

    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        fetch_req;
    logic [31:0] inst;

    assign br_taken  = br_zip[32];
    assign br_target = br_zip[31:0];
    assign flush     = wb_ex | ertn_flush | br_taken;
    assign seq_pc    = fs_pc_reg + 32'd4;

    // Exception beats ertn beats branch: a committed older event always overrides decode.
    always_comb begin
        nextpc = seq_pc;
        if (wb_ex)
            nextpc = ex_entry;
        else if (ertn_flush)
            nextpc = era;
        else if (br_taken)
            nextpc = br_target;
    end

    // A redirect discards fetch-stage content, so it is accepted even while decode stalls.
    assign fs_allowin = ~fs_valid_reg | ds_allowin | flush;
    assign fetch_req  = preif_valid_reg & fs_allowin;

    assign inst_sram.inst_sram_en    = fetch_req;
    assign inst_sram.inst_sram_we    = 4'b0;
    assign inst_sram.inst_sram_addr  = nextpc;
    assign inst_sram.inst_sram_wdata = 32'b0;

    assign inst        = buf_valid_reg ? inst_buf_reg : inst_sram.inst_sram_rdata;
    assign fs2ds_valid = fs_valid_reg & ~flush;
    assign fs2ds_bus   = {fs_pc_reg, inst};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            preif_valid_reg <= 1'b0;
            fs_valid_reg    <= 1'b0;
            buf_valid_reg   <= 1'b0;
            fs_pc_reg       <= RESET_PC - 32'd4;
            inst_buf_reg    <= 32'b0;
        end else begin
            preif_valid_reg <= 1'b1;
            if (fetch_req) begin
                fs_valid_reg  <= 1'b1;
                fs_pc_reg     <= nextpc;
                buf_valid_reg <= 1'b0;
            end else if (fs2ds_valid & ds_allowin) begin
                fs_valid_reg  <= 1'b0;
                buf_valid_reg <= 1'b0;
            end else if (fs_valid_reg & ~buf_valid_reg) begin
                // First stalled cycle: grab the SRAM word before its output can change.
                inst_buf_reg  <= inst_sram.inst_sram_rdata;
                buf_valid_reg <= 1'b1;
            end
        end
    end

endmodule
